l0_ctrl: RTL and testbench

Sequencer for the L0 row-FIFO bank feeding the systolic MAC array. On a start command it streams `len` activation vectors from the activation SRAM into L0, then drains them into the array while honouring array back-pressure. It then waits out L0's internal read skew and pulses done. It sits between the core's top-level instruction decoder and the L0 instance, and drives every L0 wr/rd strobe.

---
 rtl/l0_pkg.sv | 21 ++
 rtl/l0_ctrl_cnt.sv | 46 ++++
 rtl/l0_ctrl.sv | 177 +++++++++++++++++
 tb/tb_l0_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/l0_pkg.sv
// Shared definitions for the L0 row-FIFO sequencer.
//   L0_DEPTH / L0_ROW / L0_SKEW : default geometry of the L0 bank
//   LEN_W                       : width of vector counts (0..L0_DEPTH inclusive)
//   l0_state_e                  : sequencer FSM states
package l0_pkg;

  localparam int L0_DEPTH = 64;
  localparam int L0_ROW   = 8;
  localparam int L0_SKEW  = 3;
  localparam int LEN_W    = $clog2(L0_DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN,
    SKEW_WAIT,
    DONE
  } l0_state_e;

endpackage

// File: rtl/l0_ctrl_cnt.sv
// Loadable up-counter with terminal-count compare against a limit.
//   clk, reset  : clock, synchronous active-high reset
//   i_clr       : zero the count (takes priority over i_inc)
//   i_inc       : count one event this cycle
//   i_max       : terminal count
//   o_cnt       : current count
//   o_tc        : count has reached i_max
//   o_tc_next   : this cycle's event is the one that reaches i_max
module l0_ctrl_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_cnt,
  output logic         o_tc,
  output logic         o_tc_next
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt     = cnt_q;
  assign o_tc      = (cnt_q == i_max);
  assign o_tc_next = i_inc & ((cnt_q + W'(1)) == i_max);

endmodule

// File: rtl/l0_ctrl.sv
// L0 row-FIFO sequencer: loads len vectors from activation SRAM into L0,
// drains them into the MAC array under back-pressure, waits out the L0
// read skew and pulses o_done.
//   clk, reset     : clock, synchronous active-high reset
//   i_start        : command strobe (accepted only in IDLE)
//   i_base_addr    : first SRAM address of the command
//   i_len          : vector count, clamped to DEPTH
//   i_array_ready  : array accepts an L0 read this cycle
//   i_l0_full      : L0 full flag, stalls new SRAM reads
//   o_sram_rd      : SRAM read enable (data one cycle later)
//   o_sram_addr    : SRAM read address
//   o_l0_wr        : L0 write strobe, aligned with SRAM data
//   o_l0_rd        : L0 read strobe
//   o_busy         : command in progress
//   o_done         : one-cycle completion pulse
module l0_ctrl
  import l0_pkg::*;
#(
  parameter int ROW    = L0_ROW,
  parameter int DEPTH  = L0_DEPTH,
  parameter int ADDR_W = 11,
  parameter int SKEW   = L0_SKEW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [6:0]        i_len,
  input  logic              i_array_ready,
  input  logic              i_l0_full,
  output logic              o_sram_rd,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_l0_wr,
  output logic              o_l0_rd,
  output logic              o_busy,
  output logic              o_done
);

  localparam int SKEW_W = (SKEW > 1) ? $clog2(SKEW) : 1;
  localparam logic [SKEW_W-1:0] SKEW_LAST = SKEW_W'((SKEW > 0) ? SKEW - 1 : 0);

  // The row count only shapes L0's data path; a zero-row build has no
  // meaning and leaves this marker block in the elaborated hierarchy.
  if (ROW < 1) begin : g_row_unsupported
  end

  l0_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic              l0_wr_q, l0_wr_d;

  logic [LEN_W-1:0]  len_in;
  logic [LEN_W-1:0]  len_clamped;
  logic              cnt_clr;
  logic              sram_rd;
  logic              l0_rd;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] sram_addr;

  logic [LEN_W-1:0]  rd_cnt, wr_cnt, pop_cnt;
  logic              rd_tc, rd_tc_next;
  logic              wr_tc, wr_tc_next;
  logic              pop_tc, pop_tc_next;
  logic              unused_cnt_bits;

  assign len_in      = LEN_W'(i_len);
  assign len_clamped = (len_in > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_in;
  assign cnt_clr     = (state_q == IDLE) & i_start;

  l0_ctrl_cnt #(.W(LEN_W)) u_rd_cnt (
    .clk(clk), .reset(reset), .i_clr(cnt_clr), .i_inc(sram_rd), .i_max(len_q),
    .o_cnt(rd_cnt), .o_tc(rd_tc), .o_tc_next(rd_tc_next)
  );

  l0_ctrl_cnt #(.W(LEN_W)) u_wr_cnt (
    .clk(clk), .reset(reset), .i_clr(cnt_clr), .i_inc(l0_wr_q), .i_max(len_q),
    .o_cnt(wr_cnt), .o_tc(wr_tc), .o_tc_next(wr_tc_next)
  );

  l0_ctrl_cnt #(.W(LEN_W)) u_pop_cnt (
    .clk(clk), .reset(reset), .i_clr(cnt_clr), .i_inc(l0_rd), .i_max(len_q),
    .o_cnt(pop_cnt), .o_tc(pop_tc), .o_tc_next(pop_tc_next)
  );

  // Write and pop totals are only needed as terminal-count events.
  assign unused_cnt_bits = ^{wr_cnt, pop_cnt, wr_tc};

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    skew_d    = skew_q;
    sram_rd   = 1'b0;
    sram_addr = '0;
    l0_rd     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          base_d  = i_base_addr;
          len_d   = len_clamped;
          state_d = (len_clamped == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        sram_addr = base_q + ADDR_W'(rd_cnt);
        sram_rd   = ~rd_tc & ~i_l0_full;
        // Leave as the last read issues; its write lands in FLUSH.
        if (rd_tc_next) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (wr_tc_next) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy  = 1'b1;
        l0_rd = i_array_ready & ~pop_tc;
        if (pop_tc_next) begin
          skew_d  = '0;
          state_d = (SKEW > 0) ? SKEW_WAIT : DONE;
        end
      end
      SKEW_WAIT: begin
        busy = 1'b1;
        if (skew_q == SKEW_LAST) begin
          state_d = DONE;
        end else begin
          skew_d = skew_q + SKEW_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign l0_wr_d = sram_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      skew_q  <= '0;
      l0_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      skew_q  <= skew_d;
      l0_wr_q <= l0_wr_d;
    end
  end

  // Outputs are forced low in the reset cycle itself, so an abort never
  // leaks a final strobe into L0 or the array.
  assign o_sram_rd   = sram_rd & ~reset;
  assign o_sram_addr = reset ? '0 : sram_addr;
  assign o_l0_wr     = l0_wr_q & ~reset;
  assign o_l0_rd     = l0_rd & ~reset;
  assign o_busy      = busy & ~reset;
  assign o_done      = done & ~reset;

endmodule

// File: tb/tb_l0_ctrl.sv
module tb_l0_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [10:0] i_base_addr;
  logic [6:0]  i_len;
  logic        i_array_ready;
  logic        i_l0_full;
  logic        o_sram_rd;
  logic [10:0] o_sram_addr;
  logic        o_l0_wr;
  logic        o_l0_rd;
  logic        o_busy;
  logic        o_done;

  always #5 clk = ~clk;

  l0_ctrl dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_len(i_len), .i_array_ready(i_array_ready), .i_l0_full(i_l0_full),
    .o_sram_rd(o_sram_rd), .o_sram_addr(o_sram_addr), .o_l0_wr(o_l0_wr),
    .o_l0_rd(o_l0_rd), .o_busy(o_busy), .o_done(o_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Per-command event record, cycles relative to the start cycle (rel 0).
  int n_rd, n_wr, n_pop, n_done, n_busy, n_overlap;
  int first_rd, last_rd, first_wr, last_wr, first_pop, last_pop, done_cyc;
  int rd_addr[$];
  bit rd_at[256];
  bit pop_at[256];
  int post_rst_bits;

  task automatic run_cmd(input logic [10:0] base, input logic [6:0] len,
                         input logic [63:0] ready_pat, input logic [63:0] full_pat,
                         input int n_cyc, input int start2_cyc, input int rst_cyc);
    n_rd = 0; n_wr = 0; n_pop = 0; n_done = 0; n_busy = 0; n_overlap = 0;
    first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
    first_pop = -1; last_pop = -1; done_cyc = -1; post_rst_bits = -1;
    rd_addr.delete();
    for (int k = 0; k < 256; k++) begin
      rd_at[k] = 1'b0;
      pop_at[k] = 1'b0;
    end
    i_base_addr = base;
    i_len = len;
    for (int rel = 0; rel < n_cyc; rel++) begin
      i_start       = (rel == 0) || (rel == start2_cyc);
      i_array_ready = (rel < 64) ? ready_pat[rel] : 1'b1;
      i_l0_full     = (rel < 64) ? full_pat[rel] : 1'b0;
      reset         = (rel == rst_cyc);
      @(negedge clk);
      if (o_sram_rd) begin
        n_rd++;
        rd_addr.push_back(int'(o_sram_addr));
        rd_at[rel] = 1'b1;
        if (first_rd < 0) first_rd = rel;
        last_rd = rel;
      end
      if (o_l0_wr) begin
        n_wr++;
        if (first_wr < 0) first_wr = rel;
        last_wr = rel;
      end
      if (o_l0_rd) begin
        n_pop++;
        pop_at[rel] = 1'b1;
        if (first_pop < 0) first_pop = rel;
        last_pop = rel;
      end
      if (o_l0_wr && o_l0_rd) n_overlap++;
      if (o_busy) n_busy++;
      if (o_done) begin
        n_done++;
        done_cyc = rel;
      end
      if (rel == rst_cyc + 1) begin
        post_rst_bits = int'({o_sram_rd, o_l0_wr, o_l0_rd, o_busy, o_done}) + int'(o_sram_addr);
      end
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    reset = 1'b0;
    i_array_ready = 1'b1;
    i_l0_full = 1'b0;
    $display("cmd base=0x%03h len=%0d: rd=%0d wr=%0d pop=%0d done=%0d @%0d busy=%0d",
             base, len, n_rd, n_wr, n_pop, n_done, done_cyc, n_busy);
  endtask

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    i_base_addr = '0;
    i_len = '0;
    i_array_ready = 1'b1;
    i_l0_full = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outputs_during", int'({o_sram_rd, o_l0_wr, o_l0_rd, o_busy, o_done}), 0);
    check_eq("rst_addr_during", int'(o_sram_addr), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_outputs_after", int'({o_sram_rd, o_l0_wr, o_l0_rd, o_busy, o_done}), 0);
    @(posedge clk);
    #1;

    // Basic load/drain: reads 1..4, writes 2..5, pops 6..9, skew 10..12, done 13
    run_cmd(11'h010, 7'd4, ALL1, 64'h0, 17, -1, -1);
    check_eq("basic_n_rd", n_rd, 4);
    check_eq("basic_first_rd", first_rd, 1);
    check_eq("basic_last_rd", last_rd, 4);
    for (int k = 0; k < 4; k++)
      check_eq("basic_addr", (k < rd_addr.size()) ? rd_addr[k] : -1, 16 + k);
    check_eq("basic_first_wr", first_wr, 2);
    check_eq("basic_last_wr", last_wr, 5);
    check_eq("basic_n_wr", n_wr, 4);
    check_eq("basic_first_pop", first_pop, 6);
    check_eq("basic_last_pop", last_pop, 9);
    check_eq("basic_n_pop", n_pop, 4);
    check_eq("basic_done_cyc", done_cyc, 13);
    check_eq("basic_n_done", n_done, 1);
    check_eq("basic_busy_cycles", n_busy, 12);
    check_eq("basic_overlap", n_overlap, 0);

    // Back-pressure: drain starts rel 5, ready 1,0,0,1,1 -> pops 5,8,9, done 13
    run_cmd(11'h100, 7'd3, 64'hFFFF_FFFF_FFFF_FF3F, 64'h0, 17, -1, -1);
    check_eq("bp_n_pop", n_pop, 3);
    check_eq("bp_pop_pattern", int'({pop_at[5], pop_at[6], pop_at[7], pop_at[8], pop_at[9]}), 5'b10011);
    check_eq("bp_done_cyc", done_cyc, 13);
    check_eq("bp_n_done", n_done, 1);

    // len=0: done the cycle after start, no strobes
    run_cmd(11'h020, 7'd0, ALL1, 64'h0, 5, -1, -1);
    check_eq("len0_done_cyc", done_cyc, 1);
    check_eq("len0_strobes", n_rd + n_wr + n_pop, 0);
    check_eq("len0_busy", n_busy, 0);

    // len=100 clamps to 64: done at 1+64+1+64+3 = 133
    run_cmd(11'h000, 7'd100, ALL1, 64'h0, 137, -1, -1);
    check_eq("len100_n_rd", n_rd, 64);
    check_eq("len100_n_wr", n_wr, 64);
    check_eq("len100_n_pop", n_pop, 64);
    check_eq("len100_done_cyc", done_cyc, 133);

    // Address wrap
    run_cmd(11'h7FE, 7'd4, ALL1, 64'h0, 16, -1, -1);
    check_eq("wrap_n_rd", n_rd, 4);
    check_eq("wrap_addr0", (rd_addr.size() > 0) ? rd_addr[0] : -1, 'h7FE);
    check_eq("wrap_addr1", (rd_addr.size() > 1) ? rd_addr[1] : -1, 'h7FF);
    check_eq("wrap_addr2", (rd_addr.size() > 2) ? rd_addr[2] : -1, 'h000);
    check_eq("wrap_addr3", (rd_addr.size() > 3) ? rd_addr[3] : -1, 'h001);

    // Full stall on rel 3,4: reads 1,2,5..8, writes 2,3,6..9, pops 10..15, done 19
    run_cmd(11'h040, 7'd6, ALL1, 64'h18, 22, -1, -1);
    check_eq("full_stall_rd", int'({rd_at[3], rd_at[4]}), 0);
    check_eq("full_last_rd", last_rd, 8);
    check_eq("full_n_rd", n_rd, 6);
    check_eq("full_n_wr", n_wr, 6);
    check_eq("full_n_pop", n_pop, 6);
    check_eq("full_done_cyc", done_cyc, 19);

    // Second start during DRAIN (rel 7) is dropped
    run_cmd(11'h200, 7'd4, ALL1, 64'h0, 35, 7, -1);
    check_eq("busy_start_n_done", n_done, 1);
    check_eq("busy_start_done_cyc", done_cyc, 13);
    check_eq("busy_start_n_rd", n_rd, 4);

    // Reset in DRAIN after pops at rel 7,8; reset asserted rel 9
    run_cmd(11'h300, 7'd5, ALL1, 64'h0, 25, -1, 9);
    check_eq("rst_mid_n_pop", n_pop, 2);
    check_eq("rst_mid_n_done", n_done, 0);
    check_eq("rst_mid_outputs", post_rst_bits, 0);
    check_eq("rst_mid_busy_cycles", n_busy, 8);

    // Fresh command after abort: reads 1,2, pops 4,5, done 9
    run_cmd(11'h050, 7'd2, ALL1, 64'h0, 12, -1, -1);
    check_eq("fresh_n_pop", n_pop, 2);
    check_eq("fresh_done_cyc", done_cyc, 9);
    check_eq("fresh_n_done", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
